// File: rtl/conv_lut_stream.sv
// conv_lut_stream: turns an address stream into LUT lookups and queues the
// in-order responses (or zero-extended bypass data) in a credit-guarded FIFO.
module conv_lut_stream #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             aclk,
    input  logic             reset_p,
    input  logic             cfg_bypass,
    input  logic [IN_W-1:0]  in_tdata,
    input  logic             in_tlast,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [IN_W-1:0]  rd_addr,
    output logic             rd_read,
    input  logic [OUT_W-1:0] rd_data,
    input  logic             rd_valid,
    output logic [OUT_W-1:0] out_tdata,
    output logic             out_tlast,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [CNT_W-1:0] stat_level,
    output logic             err_unexp
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = OUT_W + 1;

    logic             r_mode;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_level;
    logic [AW-1:0]    r_tag_wp;
    logic [AW-1:0]    r_tag_rp;
    logic [DEPTH-1:0] r_tag;
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [EW-1:0]    r_mem [DEPTH];
    logic             r_err;

    logic [CNT_W:0]   w_credit;
    logic             w_mode_ok;
    logic             w_ready;
    logic             w_accept;
    logic             w_req;
    logic             w_has_out;
    logic             w_rsp;
    logic             w_bad;
    logic             w_push;
    logic             w_pop;
    logic             w_nempty;
    logic [EW-1:0]    w_wdata;
    logic [EW-1:0]    w_head;

    // Credit counts both queued entries and lookups still in flight, so
    // every response already has a FIFO slot reserved for it.
    assign w_credit  = {1'b0, r_outstanding} + {1'b0, r_level};
    assign w_mode_ok = (cfg_bypass == r_mode);
    assign w_ready   = (w_credit < (CNT_W+1)'(DEPTH)) && w_mode_ok;
    assign w_accept  = in_tvalid & w_ready;
    assign w_req     = w_accept & ~r_mode;
    assign w_has_out = (r_outstanding != '0);
    assign w_rsp     = rd_valid & w_has_out;
    assign w_bad     = rd_valid & ~w_has_out;
    assign w_push    = r_mode ? w_accept : w_rsp;
    assign w_wdata   = r_mode ? {in_tlast, OUT_W'(in_tdata)}
                              : {r_tag[r_tag_rp], rd_data};
    assign w_nempty  = (r_level != '0);
    assign w_pop     = w_nempty & out_tready;
    assign w_head    = r_mem[r_rp];

    assign in_tready  = w_ready;
    assign rd_addr    = in_tdata;
    assign rd_read    = w_req;
    assign out_tvalid = w_nempty;
    assign out_tdata  = w_nempty ? w_head[OUT_W-1:0] : '0;
    assign out_tlast  = w_nempty & w_head[OUT_W];
    assign stat_level = r_level;
    assign err_unexp  = r_err;

    // Mode only switches once every issued lookup has come back.
    always_ff @(posedge aclk or posedge reset_p) begin
        if (reset_p) begin
            r_mode <= 1'b0;
        end else if (!w_has_out) begin
            r_mode <= cfg_bypass;
        end
    end

    // Outstanding-lookup counter; request and response together cancel.
    always_ff @(posedge aclk or posedge reset_p) begin
        if (reset_p) begin
            r_outstanding <= '0;
        end else if (w_req && !w_rsp) begin
            r_outstanding <= r_outstanding + CNT_W'(1);
        end else if (!w_req && w_rsp) begin
            r_outstanding <= r_outstanding - CNT_W'(1);
        end
    end

    // Tag queue pointers: push TLAST on request, pop on response.
    always_ff @(posedge aclk or posedge reset_p) begin
        if (reset_p) begin
            r_tag_wp <= '0;
            r_tag_rp <= '0;
        end else begin
            if (w_req) r_tag_wp <= r_tag_wp + AW'(1);
            if (w_rsp) r_tag_rp <= r_tag_rp + AW'(1);
        end
    end

    // Tag storage holds the TLAST of each lookup still in flight.
    always_ff @(posedge aclk) begin
        if (w_req) r_tag[r_tag_wp] <= in_tlast;
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge aclk or posedge reset_p) begin
        if (reset_p) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            if (w_push && !w_pop) begin
                r_level <= r_level + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - CNT_W'(1);
            end
        end
    end

    // Output FIFO storage; head is read straight from the registered array.
    always_ff @(posedge aclk) begin
        if (w_push) r_mem[r_wp] <= w_wdata;
    end

    // Sticky flag for a response that matches no request.
    always_ff @(posedge aclk or posedge reset_p) begin
        if (reset_p) begin
            r_err <= 1'b0;
        end else if (w_bad) begin
            r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_conv_lut_stream.sv
// tb_conv_lut_stream: directed stimulus with a latency-modelled lookup memory
// and a queue scoreboard checked by a decoupled output monitor.
module tb_conv_lut_stream;
    logic        aclk = 1'b0;
    logic        reset_p = 1'b1;
    logic        cfg_bypass = 1'b0;
    logic [7:0]  in_tdata = '0;
    logic        in_tlast = 1'b0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [7:0]  rd_addr;
    logic        rd_read;
    logic [15:0] rd_data = '0;
    logic        rd_valid = 1'b0;
    logic [15:0] out_tdata;
    logic        out_tlast;
    logic        out_tvalid;
    logic        out_tready;
    logic [4:0]  stat_level;
    logic        err_unexp;

    logic rdy_val = 1'b1;
    logic rdy_rand = 1'b0;
    logic rnd_bit = 1'b1;

    typedef struct {
        int         due;
        logic [7:0] a;
    } req_t;

    req_t        mq[$];
    logic [16:0] sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int nout = 0;
    int tb_outs = 0;
    int last_rv_cyc = 0;
    int spur_req = 0;
    int spur_ack = 0;
    int lat = 3;
    int acc_cyc = 0;
    bit lat_rand = 1'b0;
    bit inv_en = 1'b0;

    assign out_tready = rdy_rand ? rnd_bit : rdy_val;

    conv_lut_stream dut (
        .aclk       (aclk),
        .reset_p    (reset_p),
        .cfg_bypass (cfg_bypass),
        .in_tdata   (in_tdata),
        .in_tlast   (in_tlast),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .rd_addr    (rd_addr),
        .rd_read    (rd_read),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .stat_level (stat_level),
        .err_unexp  (err_unexp)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [15:0] lut(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard push, output monitor, and lookup memory model.
    initial begin
        logic [16:0] e;
        req_t        m;
        bit          rv;
        bit          had;
        forever begin
            @(negedge aclk);
            cyc++;
            if (reset_p) begin
                sb.delete();
                tb_outs = 0;
            end else begin
                if (inv_en)
                    chk("t3_credit", 32'((tb_outs + int'(stat_level)) <= 16), 32'd1);
                if (out_tvalid && out_tready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_out got=%0h want=none",
                                 {out_tlast, out_tdata});
                    end else begin
                        e = sb.pop_front();
                        chk("out_beat", 32'({out_tlast, out_tdata}), 32'(e));
                        nout++;
                    end
                end
                if (in_tvalid && in_tready) begin
                    if (cfg_bypass) sb.push_back({in_tlast, 8'h00, in_tdata});
                    else            sb.push_back({in_tlast, lut(in_tdata)});
                end
            end
            if (rd_read) begin
                m.due = cyc + (lat_rand ? int'($urandom_range(1, 8)) : lat);
                m.a   = rd_addr;
                mq.push_back(m);
                rd_cnt++;
            end
            rv = 1'b0;
            if (spur_req != spur_ack) begin
                spur_ack = spur_req;
                rv = 1'b1;
                rd_data = 16'hDEAD;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                m = mq.pop_front();
                rv = 1'b1;
                rd_data = lut(m.a);
                last_rv_cyc = cyc;
            end
            rd_valid = rv;
            if (!reset_p) begin
                had = (tb_outs > 0);
                if (rd_read) tb_outs++;
                if (rv && had) tb_outs--;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        in_tdata  = d;
        in_tlast  = l;
        in_tvalid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge aclk);
            ok = in_tready;
            @(posedge aclk);
            #1;
        end
        in_tvalid = 1'b0;
        acc_cyc = cyc;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=stalled want=accept data=%0h", d);
        end
    endtask

    task automatic drain(input string nm);
        int i;
        i = 0;
        while ((sb.size() != 0 || out_tvalid) && i < 2000) begin
            @(posedge aclk);
            #1;
            i++;
        end
        chk(nm, 32'(sb.size()), 32'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int r0;
        cycles(3);
        chk("rst_tready", 32'(in_tready), 32'd1);
        chk("rst_tvalid", 32'(out_tvalid), 32'd0);
        chk("rst_tlast", 32'(out_tlast), 32'd0);
        chk("rst_tdata", 32'(out_tdata), 32'd0);
        chk("rst_level", 32'(stat_level), 32'd0);
        chk("rst_rdread", 32'(rd_read), 32'd0);
        chk("rst_err", 32'(err_unexp), 32'd0);
        reset_p = 1'b0;
        cycles(2);

        // T1: fixed latency 3, addresses 0..15.
        lat = 3;
        n0 = nout;
        for (int i = 0; i < 16; i++) send(8'(i), i == 15);
        drain("t1_drain");
        chk("t1_count", 32'(nout - n0), 32'd16);
        chk("t1_err", 32'(err_unexp), 32'd0);

        // T2: back-pressure fills FIFO, then release.
        rdy_val = 1'b0;
        n0 = nout;
        r0 = rd_cnt;
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i), (i % 8) == 7);
        in_tdata  = 8'h50;
        in_tlast  = 1'b0;
        in_tvalid = 1'b1;
        cycles(12);
        chk("t2_reads", 32'(rd_cnt - r0), 32'd16);
        chk("t2_level", 32'(stat_level), 32'd16);
        chk("t2_tready", 32'(in_tready), 32'd0);
        chk("t2_head", 32'({out_tlast, out_tdata}), 32'({1'b0, lut(8'h40)}));
        rdy_val = 1'b1;
        for (int i = 16; i < 40; i++) send(8'(8'h40 + i), (i % 8) == 7);
        drain("t2_drain");
        chk("t2_count", 32'(nout - n0), 32'd40);

        // T3: random latency and random output ready.
        lat_rand = 1'b1;
        rdy_rand = 1'b1;
        inv_en   = 1'b1;
        n0 = nout;
        for (int i = 0; i < 60; i++) send(8'(i * 7 + 3), (i % 5) == 4);
        drain("t3_drain");
        chk("t3_count", 32'(nout - n0), 32'd60);
        inv_en   = 1'b0;
        rdy_rand = 1'b0;
        lat_rand = 1'b0;

        // T4: request bypass with 5 lookups in flight.
        lat = 8;
        for (int i = 0; i < 5; i++) send(8'(8'h90 + i), 1'b0);
        r0 = rd_cnt;
        cfg_bypass = 1'b1;
        send(8'hA5, 1'b1);
        chk("t4_after_rsp", 32'(acc_cyc > last_rv_cyc), 32'd1);
        chk("t4_no_read", 32'(rd_cnt - r0), 32'd0);
        drain("t4_drain");
        cfg_bypass = 1'b0;
        cycles(3);

        // T5: spurious response with nothing outstanding.
        lat = 2;
        rdy_val = 1'b0;
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        cycles(6);
        chk("t5_level_pre", 32'(stat_level), 32'd2);
        chk("t5_err_pre", 32'(err_unexp), 32'd0);
        spur_req++;
        cycles(4);
        chk("t5_err", 32'(err_unexp), 32'd1);
        chk("t5_level", 32'(stat_level), 32'd2);
        cycles(5);
        chk("t5_err_hold", 32'(err_unexp), 32'd1);
        rdy_val = 1'b1;
        drain("t5_drain");

        // T6: reset with 4 queued and 3 outstanding.
        lat = 8;
        rdy_val = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), 1'b0);
        cycles(12);
        chk("t6_level4", 32'(stat_level), 32'd4);
        for (int i = 0; i < 3; i++) send(8'(8'hD0 + i), 1'b0);
        reset_p = 1'b1;
        #1;
        chk("t6_tvalid", 32'(out_tvalid), 32'd0);
        chk("t6_level", 32'(stat_level), 32'd0);
        chk("t6_err_clr", 32'(err_unexp), 32'd0);
        cycles(2);
        reset_p = 1'b0;
        chk("t6_tready", 32'(in_tready), 32'd1);
        cycles(12);
        chk("t6_err_late", 32'(err_unexp), 32'd1);
        chk("t6_level_late", 32'(stat_level), 32'd0);
        chk("t6_tvalid_late", 32'(out_tvalid), 32'd0);
        rdy_val = 1'b1;
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
